bioram_arb: RTL
===============

// Module: bioram_arb
// PURPOSE
//   Two-requester access arbiter and sequencer for the 1Kx32 BIO single-port SRAM macro.
//   Shares the macro between port 0 (host bus bridge) and port 1 (BIO core data port).
//   Drives the macro's active-low enable and write-mask pins and returns read data one cycle after grant.
//   Supports a bounded lock so one requester can issue back-to-back accesses (read-modify-write).
// PARAMETERS
//   ADDR_W    10  word address width (1K words)
//   DATA_W    32  data width; must be a multiple of 8
//   MAX_LOCK  4   max consecutive locked grants to one port before forced release; range 1..15
// PORTS
//   clk            in   1       clock
//   reset_n        in   1       synchronous active-low reset
//   pN_req         in   1       N=0,1: access request; command fields must be stable while req=1 and gnt=0
//   pN_we          in   1       1=write, 0=read
//   pN_be          in   DATA_W/8  byte enables for writes
//   pN_addr        in   ADDR_W  word address
//   pN_wdata       in   DATA_W  write data
//   pN_lock        in   1       request to keep the grant for this port's next access
//   pN_gnt         out  1       combinational accept; the access occurs this cycle
//   pN_rvalid      out  1       read data valid; exactly 1 cycle after a read grant
//   pN_rdata       out  DATA_W  read data; equals ram_q, meaningful only while pN_rvalid=1
//   ram_cen        out  1       macro chip enable, active low
//   ram_gwen       out  1       macro global write enable, active low
//   ram_wen        out  DATA_W  macro per-bit write mask, active low
//   ram_a          out  ADDR_W  macro address
//   ram_d          out  DATA_W  macro write data
//   ram_q          in   DATA_W  macro read data (holds its value while cen=1)
// BEHAVIOUR
//   Reset (reset_n=0 at a clk edge): the following take effect after that edge.
//     - pN_gnt=0 and pN_rvalid=0 for both ports.
//     - ram_cen=1, ram_gwen=1, ram_wen=all 1s.
//     - last_winner=1, lock_owner=none, lock_cnt=0.
//     - A read response that was pending is dropped.
//   Grant is combinational. At most one pN_gnt is high per cycle. A grant is issued only to a port with req=1.
//   Selection order:
//     (a) If lock_owner is set, its req=1, and lock_cnt<MAX_LOCK: grant the owner.
//     (b) Otherwise apply the base policy (see CONFIGURATION).
//     (c) On a forced release (lock_cnt==MAX_LOCK), the non-owner wins if it is requesting.
//   Macro drive in a granted cycle:
//     - ram_cen=0; ram_a and ram_d come from the winner.
//     - ram_gwen = ~(we & |be).
//     - ram_wen[8b+:8] = {8{~be[b]}}.
//   Macro drive in an idle cycle: ram_cen=1, ram_gwen=1, ram_wen=all 1s, and ram_a/ram_d hold their last values.
//   Reads: the winner's pN_rvalid=1 in the next cycle only; pN_rdata=ram_q. A write never raises rvalid.
//   A write with be=0 is granted and consumes the slot, but the macro is not written.
//   Lock state, updated on every grant edge:
//     - If the winner's lock=1: lock_owner=winner. lock_cnt=lock_cnt+1 if the winner was already the owner, else 1.
//     - If the winner's lock=0: lock_owner=none, lock_cnt=0.
//     - If the owner's req is 0 for a cycle: the lock is cleared.
//     - A forced release clears lock_owner and lock_cnt.
//   last_winner is updated on every grant. No grant means no state change except the lock clear above.
//   Back-to-back: a new grant may be issued in the same cycle as rvalid for the previous read. Throughput is 1 access/cycle.
// CONFIGURATION
//   Macro BIORAM_ARB_RR_EN:
//     - Defined: round-robin base policy; the port != last_winner wins on a tie.
//     - Undefined: fixed priority, port 0 wins on a tie. The MAX_LOCK forced release still bounds port-1 starvation by a port-0 lock only.
//   Tie-offs: ema/emaw/emas/wabl/rawl pins are driven by the instantiating wrapper, not by this block.
// STRUCTURE
//   bioram_pkg holds:
//     - BIORAM_ADDR_W, BIORAM_DATA_W, BIORAM_BE_W.
//     - typedef bioram_cmd_t {we, be, addr, wdata, lock}.
//     - enum bioram_port_e {PORT_HOST, PORT_BIO}.
//   One sub-module, bioram_arb_pick: the combinational 2-way picker (req, last_winner, lock state -> winner).
//   The lock counter and the response pipeline stay in the top level.
// TESTING
//   1. Reset mid-read: p0 read is granted, reset_n=0 next edge -> p0_rvalid=0, ram_cen=1, ram_wen=32'hFFFFFFFF.
//   2. Byte write then read:
//      - p1 write addr 0x3FF, wdata 0xA5A5A5A5, be=4'b0101 -> ram_wen=32'hFF00FF00, ram_gwen=0.
//      - A later read returns 0x??A5??A5 with the old bytes kept, rvalid exactly 1 cycle after gnt.
//   3. Contention: both ports request every cycle for 8 cycles.
//      - RR_EN defined: gnt alternates 0,1,0,1...
//      - RR_EN undefined: p0 wins all 8.
//   4. Lock bound, MAX_LOCK=4: p0 holds lock=1 with req=1 continuously and p1 also requests.
//      - p0 gets 4 consecutive grants, then p1 gets 1; the lock is released.
//   5. Wrap and no-op: read addr 0x3FF then 0x000 back-to-back -> two rvalid pulses on consecutive cycles.
//      A be=0 write -> gnt=1, ram_gwen=1, memory unchanged.

Source files
------------

// File: rtl/bioram_pkg.sv
// bioram_pkg: shared widths, command bundle and port ids for the BIO SRAM arbiter.
// Consumed by bioram_arb and bioram_arb_pick.
package bioram_pkg;

    localparam int BIORAM_ADDR_W   = 10;
    localparam int BIORAM_DATA_W   = 32;
    localparam int BIORAM_BE_W     = BIORAM_DATA_W / 8;
    localparam int BIORAM_MAX_LOCK = 4;

    typedef enum logic {
        PORT_HOST = 1'b0,
        PORT_BIO  = 1'b1
    } bioram_port_e;

    typedef struct packed {
        logic                     we;
        logic [BIORAM_BE_W-1:0]   be;
        logic [BIORAM_ADDR_W-1:0] addr;
        logic [BIORAM_DATA_W-1:0] wdata;
        logic                     lock;
    } bioram_cmd_t;

endpackage

// File: rtl/bioram_arb_pick.sv
// bioram_arb_pick: combinational 2-way picker (lock owner, forced release, base policy).
// BIORAM_ARB_RR_EN selects round-robin ties; otherwise port 0 wins ties.
module bioram_arb_pick
    import bioram_pkg::*;
(
    input  logic [1:0]   req_i,
    input  bioram_port_e last_i,
    input  logic         lock_vld_i,
    input  bioram_port_e lock_own_i,
    input  logic         lock_max_i,
    output logic         any_o,
    output bioram_port_e win_o
);

`ifdef BIORAM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    bioram_port_e oth;
    bioram_port_e tie_win;
    logic         own_req;
    logic         oth_req;

    // Owner keeps the slot until its budget runs out, then the other port gets it
    always_comb begin
        oth     = (lock_own_i == PORT_HOST) ? PORT_BIO : PORT_HOST;
        own_req = req_i[lock_own_i];
        oth_req = req_i[oth];
        tie_win = PORT_HOST;
        if (RR_EN && (last_i == PORT_HOST)) begin
            tie_win = PORT_BIO;
        end
        any_o = |req_i;
        win_o = PORT_HOST;
        if (lock_vld_i && own_req && !lock_max_i) begin
            win_o = lock_own_i;
        end else if (lock_vld_i && lock_max_i && oth_req) begin
            win_o = oth;
        end else if (req_i == 2'b11) begin
            win_o = tie_win;
        end else if (req_i[1]) begin
            win_o = PORT_BIO;
        end
    end

endmodule

// File: rtl/bioram_arb.sv
// bioram_arb: two-requester arbiter/sequencer for the 1Kx32 BIO single-port SRAM macro.
// Optional macro BIORAM_ARB_RR_EN: round-robin base policy instead of fixed port-0 priority.
module bioram_arb
    import bioram_pkg::*;
#(
    parameter int ADDR_W   = BIORAM_ADDR_W,
    parameter int DATA_W   = BIORAM_DATA_W,
    parameter int MAX_LOCK = BIORAM_MAX_LOCK
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                p0_req,
    input  logic                p0_we,
    input  logic [DATA_W/8-1:0] p0_be,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic [DATA_W-1:0]   p0_wdata,
    input  logic                p0_lock,
    output logic                p0_gnt,
    output logic                p0_rvalid,
    output logic [DATA_W-1:0]   p0_rdata,
    input  logic                p1_req,
    input  logic                p1_we,
    input  logic [DATA_W/8-1:0] p1_be,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [DATA_W-1:0]   p1_wdata,
    input  logic                p1_lock,
    output logic                p1_gnt,
    output logic                p1_rvalid,
    output logic [DATA_W-1:0]   p1_rdata,
    output logic                ram_cen,
    output logic                ram_gwen,
    output logic [DATA_W-1:0]   ram_wen,
    output logic [ADDR_W-1:0]   ram_a,
    output logic [DATA_W-1:0]   ram_d,
    input  logic [DATA_W-1:0]   ram_q
);

    localparam int         BE_W    = DATA_W / 8;
    localparam logic [3:0] MAX_CNT = 4'(MAX_LOCK);

    bioram_cmd_t  cmd [2];
    bioram_cmd_t  win_cmd;
    bioram_port_e win;
    logic         any;

    bioram_port_e last_q, last_d;
    logic         lock_vld_q, lock_vld_d;
    bioram_port_e lock_own_q, lock_own_d;
    logic [3:0]   lock_cnt_q, lock_cnt_d;
    logic [1:0]   rvalid_q, rvalid_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic         lock_max;

    assign cmd[0] = '{we: p0_we, be: p0_be, addr: p0_addr,
                      wdata: p0_wdata, lock: p0_lock};
    assign cmd[1] = '{we: p1_we, be: p1_be, addr: p1_addr,
                      wdata: p1_wdata, lock: p1_lock};
    assign lock_max = lock_vld_q && (lock_cnt_q == MAX_CNT);

    bioram_arb_pick u_pick (
        .req_i      ({p1_req, p0_req}),
        .last_i     (last_q),
        .lock_vld_i (lock_vld_q),
        .lock_own_i (lock_own_q),
        .lock_max_i (lock_max),
        .any_o      (any),
        .win_o      (win)
    );

    assign win_cmd   = cmd[win];
    assign p0_gnt    = any && (win == PORT_HOST);
    assign p1_gnt    = any && (win == PORT_BIO);
    assign p0_rvalid = rvalid_q[0];
    assign p1_rvalid = rvalid_q[1];
    assign p0_rdata  = ram_q;
    assign p1_rdata  = ram_q;

    // Macro pins: live command when granted, parked (address/data held) when idle
    always_comb begin
        ram_cen  = ~any;
        ram_gwen = ~(any && win_cmd.we && (|win_cmd.be));
        for (int b = 0; b < BE_W; b++) begin
            ram_wen[8*b +: 8] = {8{~(any && win_cmd.be[b])}};
        end
        a_d   = any ? win_cmd.addr : a_q;
        d_d   = any ? win_cmd.wdata : d_q;
        ram_a = a_d;
        ram_d = d_d;
    end

    // Next lock/last-winner/response state; lock drops when owner idles or budget is spent
    always_comb begin
        last_d     = last_q;
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        lock_cnt_d = lock_cnt_q;
        rvalid_d   = 2'b00;
        if (lock_vld_q && (!cmd_req(lock_own_q) || lock_max)) begin
            lock_vld_d = 1'b0;
            lock_cnt_d = 4'd0;
        end
        if (any) begin
            last_d = win;
            rvalid_d[win] = ~win_cmd.we;
            if (win_cmd.lock) begin
                lock_cnt_d = (lock_vld_d && (lock_own_q == win))
                           ? lock_cnt_q + 4'd1 : 4'd1;
                lock_vld_d = 1'b1;
                lock_own_d = win;
            end else begin
                lock_vld_d = 1'b0;
                lock_cnt_d = 4'd0;
            end
        end
    end

    function automatic logic cmd_req(bioram_port_e p);
        return (p == PORT_HOST) ? p0_req : p1_req;
    endfunction

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q     <= PORT_BIO;
            lock_vld_q <= 1'b0;
            lock_own_q <= PORT_HOST;
            lock_cnt_q <= 4'd0;
            rvalid_q   <= 2'b00;
            a_q        <= '0;
            d_q        <= '0;
        end else begin
            last_q     <= last_d;
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid_q   <= rvalid_d;
            a_q        <= a_d;
            d_q        <= d_d;
        end
    end

endmodule
